// File: rtl/fpu_issue.sv
// Single-precision FPU issue/sequencing front-end: runs compare, sign-inject, min/max and
// classify internally, and hands arithmetic ops to an external unit. Optional watchdog: FPU_ISSUE_TIMEOUT_EN.
module fpu_issue #(
    parameter int FLEN    = 32,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [2:0]      in_rm,
    input  logic [FLEN-1:0] rs1,
    input  logic [FLEN-1:0] rs2,
    input  logic [2:0]      frm,
    output logic            ext_start,
    output logic [2:0]      ext_op,
    output logic [2:0]      ext_rm,
    output logic [FLEN-1:0] ext_a,
    output logic [FLEN-1:0] ext_b,
    input  logic            ext_done,
    input  logic [FLEN-1:0] ext_result,
    input  logic [4:0]      ext_flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] result,
    output logic [4:0]      out_flags,
    output logic            err,
    input  logic            flags_clr,
    output logic [4:0]      fflags
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_INT      = 2'd1;
    localparam logic [1:0] S_EXT_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [FLEN-1:0] CANON_NAN = FLEN'(32'h7FC0_0000);

    // Only FLEN=32, LAT in 1..4 and a positive TIMEOUT are meaningful configurations.
    if (FLEN != 32 || LAT < 1 || LAT > 4 || TIMEOUT < 1) begin : g_unsupported_config
    end

    logic [1:0]      state;
    logic [4:0]      op_q;
    logic [2:0]      rm_q;
    logic [FLEN-1:0] a_q;
    logic [FLEN-1:0] b_q;
    logic [1:0]      cnt;
    logic            ext_start_q;
    logic [FLEN-1:0] res_q;
    logic [4:0]      flags_q;
    logic            err_q;
    logic [4:0]      fflags_q;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Total order on non-NaN values where -0 sorts below +0.
    function automatic logic ord_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31];
        else if (!a[31])
            return a[30:0] < b[30:0];
        else
            return a[30:0] > b[30:0];
    endfunction

    function automatic logic [9:0] class_of(input logic [31:0] x);
        logic [9:0] c;
        c = 10'd0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0)
                c[x[31] ? 0 : 7] = 1'b1;
            else
                c[x[22] ? 9 : 8] = 1'b1;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0)
                c[x[31] ? 3 : 4] = 1'b1;
            else
                c[x[31] ? 2 : 5] = 1'b1;
        end else begin
            c[x[31] ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    logic [2:0] eff_rm;
    logic       op_ext;
    logic       op_legal;
    logic       op_illegal;
    logic       accept;

    assign eff_rm     = (in_rm == 3'd7) ? frm : in_rm;
    assign op_ext     = (in_op <= 5'd4);
    assign op_legal   = op_ext || ((in_op >= 5'd8) && (in_op <= 5'd16));
    assign op_illegal = !op_legal || (op_ext && ((eff_rm == 3'd5) || (eff_rm == 3'd6)));
    assign accept     = in_valid && (state == S_IDLE);

    logic a_nan, b_nan, any_nan, any_snan, both_zero, lt_ord, eq_v, lt_v;

    assign a_nan     = is_nan(a_q);
    assign b_nan     = is_nan(b_q);
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = is_snan(a_q) || is_snan(b_q);
    assign both_zero = is_zero(a_q) && is_zero(b_q);
    assign lt_ord    = ord_lt(a_q, b_q);
    assign eq_v      = !any_nan && ((a_q == b_q) || both_zero);
    assign lt_v      = !any_nan && !both_zero && lt_ord;

    logic [FLEN-1:0] int_res;
    logic [4:0]      int_flags;

    always_comb begin
        int_res   = '0;
        int_flags = '0;
        case (op_q)
            5'd8, 5'd9: begin
                if (a_nan && b_nan)
                    int_res = CANON_NAN;
                else if (a_nan)
                    int_res = b_q;
                else if (b_nan)
                    int_res = a_q;
                else
                    int_res = ((op_q == 5'd8) == lt_ord) ? a_q : b_q;
                int_flags[4] = any_snan;
            end
            5'd10: int_res = {22'd0, class_of(a_q)};
            5'd11: int_res = {b_q[31], a_q[30:0]};
            5'd12: int_res = {~b_q[31], a_q[30:0]};
            5'd13: int_res = {a_q[31] ^ b_q[31], a_q[30:0]};
            5'd14: begin
                int_res      = {31'd0, eq_v};
                int_flags[4] = any_snan;
            end
            5'd15: begin
                int_res      = {31'd0, lt_v};
                int_flags[4] = any_nan;
            end
            5'd16: begin
                int_res      = {31'd0, eq_v || lt_v};
                int_flags[4] = any_nan;
            end
            default: ;
        endcase
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            tmo_cnt <= '0;
        else if (accept)
            tmo_cnt <= '0;
        else if (state == S_EXT_WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    logic            enter_done;
    logic [FLEN-1:0] next_res;
    logic [4:0]      next_flags;
    logic            next_err;

    always_comb begin
        enter_done = 1'b0;
        next_res   = '0;
        next_flags = '0;
        next_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && op_illegal) begin
                    enter_done = 1'b1;
                    next_err   = 1'b1;
                end
            end
            S_INT: begin
                if (cnt == 2'(LAT - 1)) begin
                    enter_done = 1'b1;
                    next_res   = int_res;
                    next_flags = int_flags;
                end
            end
            S_EXT_WAIT: begin
                if (ext_done) begin
                    enter_done = 1'b1;
                    next_res   = ext_result;
                    next_flags = ext_flags;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    enter_done = 1'b1;
                    next_res   = CANON_NAN;
                    next_flags = 5'h10;
                    next_err   = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Illegal requests are still accepted so the consumer always sees a response with err set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            op_q        <= '0;
            rm_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            ext_start_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ext_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= in_op;
                        rm_q <= eff_rm;
                        a_q  <= rs1;
                        b_q  <= rs2;
                        cnt  <= '0;
                        if (op_illegal) begin
                            state <= S_DONE;
                        end else if (op_ext) begin
                            state       <= S_EXT_WAIT;
                            ext_start_q <= 1'b1;
                        end else begin
                            state <= S_INT;
                        end
                    end
                end
                S_INT: begin
                    if (!enter_done)
                        cnt <= cnt + 2'd1;
                end
                S_EXT_WAIT: ;
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (enter_done) begin
                state   <= S_DONE;
                res_q   <= next_res;
                flags_q <= next_flags;
                err_q   <= next_err;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            fflags_q <= '0;
        else if (enter_done)
            fflags_q <= (flags_clr ? 5'd0 : fflags_q) | next_flags;
        else if (flags_clr)
            fflags_q <= '0;
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign ext_start = ext_start_q;
    assign ext_op    = op_q[2:0];
    assign ext_rm    = rm_q;
    assign ext_a     = a_q;
    assign ext_b     = b_q;
    assign result    = res_q;
    assign out_flags = flags_q;
    assign err       = err_q;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: table of internal/illegal ops plus hand sequences for the
// external handshake, back-pressure, mid-operation reset and (with FPU_ISSUE_TIMEOUT_EN) the watchdog.
module tb_fpu_issue;

    localparam int LAT = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  frm;
    logic        ext_start;
    logic [2:0]  ext_op;
    logic [2:0]  ext_rm;
    logic [31:0] ext_a;
    logic [31:0] ext_b;
    logic        ext_done;
    logic [31:0] ext_result;
    logic [4:0]  ext_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_flags;
    logic        err;
    logic        flags_clr;
    logic [4:0]  fflags;

    always #5 clk = ~clk;

    fpu_issue #(.FLEN(32), .LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rm(in_rm),
        .rs1(rs1), .rs2(rs2), .frm(frm),
        .ext_start(ext_start), .ext_op(ext_op), .ext_rm(ext_rm), .ext_a(ext_a), .ext_b(ext_b),
        .ext_done(ext_done), .ext_result(ext_result), .ext_flags(ext_flags),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_flags(out_flags),
        .err(err), .flags_clr(flags_clr), .fflags(fflags)
    );

    int checks   = 0;
    int failures = 0;
    int starts   = 0;

    always @(posedge clk) begin
        if (ext_start)
            starts++;
    end

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        err;
        logic        is_int;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm_v,
                                  input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rm    = rm;
        frm      = frm_v;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic clear_flags();
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
    endtask

    initial begin
        int cyc;
        int s0;
        logic [31:0] held;

        vecs[0]  = '{5'd8,  3'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h3F800000, 5'h00, 1'b0, 1'b1};
        vecs[1]  = '{5'd8,  3'd0, 3'd0, 32'h00000000, 32'h80000000, 32'h80000000, 5'h00, 1'b0, 1'b1};
        vecs[2]  = '{5'd9,  3'd0, 3'd0, 32'h7F800001, 32'h3F800000, 32'h3F800000, 5'h10, 1'b0, 1'b1};
        vecs[3]  = '{5'd10, 3'd0, 3'd0, 32'hFF800000, 32'h00000000, 32'h00000001, 5'h00, 1'b0, 1'b1};
        vecs[4]  = '{5'd15, 3'd0, 3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h10, 1'b0, 1'b1};
        vecs[5]  = '{5'd14, 3'd0, 3'd0, 32'h80000000, 32'h00000000, 32'h00000001, 5'h00, 1'b0, 1'b1};
        vecs[6]  = '{5'd16, 3'd0, 3'd0, 32'hBF800000, 32'h3F800000, 32'h00000001, 5'h00, 1'b0, 1'b1};
        vecs[7]  = '{5'd12, 3'd0, 3'd0, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'h00, 1'b0, 1'b1};
        vecs[8]  = '{5'd13, 3'd0, 3'd0, 32'hBF800000, 32'hC0000000, 32'h3F800000, 5'h00, 1'b0, 1'b1};
        vecs[9]  = '{5'd10, 3'd0, 3'd0, 32'h7FC00000, 32'h00000000, 32'h00000200, 5'h00, 1'b0, 1'b1};
        vecs[10] = '{5'd10, 3'd0, 3'd0, 32'h00000001, 32'h00000000, 32'h00000020, 5'h00, 1'b0, 1'b1};
        vecs[11] = '{5'd9,  3'd0, 3'd0, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 5'h00, 1'b0, 1'b1};
        vecs[12] = '{5'd14, 3'd0, 3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h00, 1'b0, 1'b1};
        vecs[13] = '{5'd8,  3'd0, 3'd0, 32'h7F800001, 32'h7FC00000, 32'h7FC00000, 5'h10, 1'b0, 1'b1};
        vecs[14] = '{5'd11, 3'd0, 3'd0, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00, 1'b0, 1'b1};
        vecs[15] = '{5'd3,  3'd5, 3'd0, 32'h3F800000, 32'h40000000, 32'h00000000, 5'h00, 1'b1, 1'b0};
        vecs[16] = '{5'd20, 3'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h00000000, 5'h00, 1'b1, 1'b0};
        vecs[17] = '{5'd4,  3'd7, 3'd6, 32'h40800000, 32'h00000000, 32'h00000000, 5'h00, 1'b1, 1'b0};
        vecs[18] = '{5'd9,  3'd0, 3'd0, 32'h40000000, 32'h3F800000, 32'h40000000, 5'h00, 1'b0, 1'b1};
        vecs[19] = '{5'd15, 3'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h00000001, 5'h00, 1'b0, 1'b1};
        vecs[20] = '{5'd16, 3'd0, 3'd0, 32'h40000000, 32'h40000000, 32'h00000001, 5'h00, 1'b0, 1'b1};
        vecs[21] = '{5'd8,  3'd0, 3'd0, 32'hBF800000, 32'hC0000000, 32'hC0000000, 5'h00, 1'b0, 1'b1};
        vecs[22] = '{5'd5,  3'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h00000000, 5'h00, 1'b1, 1'b0};

        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rm      = '0;
        rs1        = '0;
        rs2        = '0;
        frm        = '0;
        ext_done   = 1'b0;
        ext_result = '0;
        ext_flags  = '0;
        out_ready  = 1'b0;
        flags_clr  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_ext_start", {31'd0, ext_start}, 32'd0);
        check_output("rst_result", result, 32'd0);
        check_output("rst_fflags", {27'd0, fflags}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table of internal and illegal operations
        for (int i = 0; i < NV; i++) begin
            clear_flags();
            s0 = starts;
            apply_stimulus(vecs[i].op, vecs[i].rm, vecs[i].frm, vecs[i].a, vecs[i].b);
            wait_valid(cyc);
            check_output($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check_output($sformatf("vec%0d_result", i), result, vecs[i].res);
            check_output($sformatf("vec%0d_out_flags", i), {27'd0, out_flags}, {27'd0, vecs[i].flg});
            check_output($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            check_output($sformatf("vec%0d_fflags", i), {27'd0, fflags}, {27'd0, vecs[i].flg});
            if (vecs[i].is_int)
                check_output($sformatf("vec%0d_latency", i), cyc, LAT);
            finish_op();
            check_output($sformatf("vec%0d_no_ext_start", i), starts - s0, 32'd0);
            check_output($sformatf("vec%0d_in_ready_after", i), {31'd0, in_ready}, 32'd1);
        end

        // Sticky NV survives the handshake, then flags_clr wipes it
        clear_flags();
        apply_stimulus(5'd9, 3'd0, 3'd0, 32'h7F800001, 32'h3F800000);
        wait_valid(cyc);
        finish_op();
        check_output("sticky_nv_kept", {27'd0, fflags}, 32'h10);
        clear_flags();
        check_output("sticky_cleared", {27'd0, fflags}, 32'h0);

        // External FADD with dynamic rounding, then back-pressure on the result
        s0 = starts;
        apply_stimulus(5'd0, 3'd7, 3'd3, 32'h3F800000, 32'h40000000);
        check_output("fadd_ext_start", {31'd0, ext_start}, 32'd1);
        check_output("fadd_ext_rm", {29'd0, ext_rm}, 32'd3);
        check_output("fadd_ext_op", {29'd0, ext_op}, 32'd0);
        @(posedge clk);
        #1;
        check_output("fadd_start_one_cycle", {31'd0, ext_start}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("fadd_ext_a_held", ext_a, 32'h3F800000);
        check_output("fadd_ext_b_held", ext_b, 32'h40000000);
        check_output("fadd_no_early_valid", {31'd0, out_valid}, 32'd0);
        ext_done   = 1'b1;
        ext_result = 32'h40400000;
        ext_flags  = 5'h01;
        @(posedge clk);
        #1;
        ext_done   = 1'b0;
        ext_result = '0;
        ext_flags  = '0;
        check_output("fadd_out_valid", {31'd0, out_valid}, 32'd1);
        check_output("fadd_result", result, 32'h40400000);
        check_output("fadd_out_flags", {27'd0, out_flags}, 32'h01);
        check_output("fadd_fflags_nx", {31'd0, fflags[0]}, 32'd1);
        check_output("fadd_start_count", starts - s0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            check_output($sformatf("hold%0d_result", k), result, 32'h40400000);
            check_output($sformatf("hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        finish_op();
        check_output("fadd_released", {31'd0, out_valid}, 32'd0);
        check_output("fadd_in_ready_back", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of an external op; the late ext_done must be ignored
        apply_stimulus(5'd2, 3'd0, 3'd0, 32'h40000000, 32'h40400000);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_output("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("midrst_fflags", {27'd0, fflags}, 32'd0);
        check_output("midrst_ext_a", ext_a, 32'd0);
        check_output("midrst_ext_rm", {29'd0, ext_rm}, 32'd0);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        ext_done   = 1'b1;
        ext_result = 32'h12345678;
        ext_flags  = 5'h1F;
        @(posedge clk);
        #1;
        ext_done   = 1'b0;
        ext_result = '0;
        ext_flags  = '0;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("late_done%0d_out_valid", k), {31'd0, out_valid}, 32'd0);
            check_output($sformatf("late_done%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        check_output("late_done_result", result, 32'd0);
        check_output("late_done_fflags", {27'd0, fflags}, 32'd0);

`ifdef FPU_ISSUE_TIMEOUT_EN
        // Watchdog: no ext_done at all
        apply_stimulus(5'd3, 3'd1, 3'd0, 32'h3F800000, 32'h00000000);
        wait_valid(cyc);
        check_output("tmo_out_valid", {31'd0, out_valid}, 32'd1);
        check_output("tmo_latency", cyc, TMO);
        check_output("tmo_result", result, 32'h7FC00000);
        check_output("tmo_err", {31'd0, err}, 32'd1);
        check_output("tmo_out_flags", {27'd0, out_flags}, 32'h10);
        held       = result;
        ext_done   = 1'b1;
        ext_result = 32'h00000001;
        @(posedge clk);
        #1;
        ext_done   = 1'b0;
        ext_result = '0;
        check_output("tmo_late_done_ignored", result, held);
        finish_op();
        check_output("tmo_in_ready_back", {31'd0, in_ready}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
